mips_hex_loader: RTL and testbench
==================================

# mips_hex_loader

Switch-and-button hex entry block for the MIPS FPGA top, the input-side counterpart of the PC/write-data seven-segment display. It debounces two push buttons and assembles a 32-bit word one hex nibble at a time from the slide switches. It then writes the completed word into instruction/data memory over a valid/ready port, so a program can be typed into the board by hand. Its running entry word and nibble count are exported so the top can show them on the HEX displays.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable cycles needed before a button level is accepted; the board build sets 500000.
- ADDR_W, 8: word-address width of the memory write port.

Ports:
- clk  in  1  system clock (CLOCK_50 at the top).
- rst  in  1  reset; one clock; synchronous, active-low.
- key_nibble  in  4  hex digit from the slide switches, sampled on the enter event.
- key_enter  in  1  raw enter button, active-high, asynchronous to clk.
- key_commit  in  1  raw commit button, active-high, asynchronous to clk.
- wr_valid  out  1  write request.
- wr_ready  in  1  memory accepts the write.
- wr_addr  out  ADDR_W  word address of the write.
- wr_data  out  32  word to write.
- entry_word  out  32  word assembled so far.
- nibble_cnt  out  4  nibbles entered, 0..8.
- busy  out  1  high while in WRITE.
- err  out  1  one-cycle pulse when a commit is rejected.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debouncer keeps a stable level and a counter.
  - The counter increments each cycle the synchronized input differs from the stable level, and clears on any cycle it matches.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - A registered rising-edge detect on the stable level gives a one-cycle press pulse. Releases produce no pulse.
- FSM states: IDLE, WRITE.
- IDLE, enter pulse:
  - entry_word <= {entry_word[27:0], key_nibble}.
  - nibble_cnt increments and saturates at 8.
  - Once the count is 8, further enters keep shifting and the oldest nibble is dropped.
- IDLE, commit pulse with nibble_cnt==8:
  - wr_data <= entry_word, and go to WRITE.
  - wr_valid and busy are high from the next cycle.
- IDLE, commit pulse with nibble_cnt<8: err pulses for one cycle and state is unchanged.
- IDLE, enter and commit pulses in the same cycle: commit takes priority and the enter is discarded.
- WRITE:
  - wr_valid stays high. wr_addr and wr_data are held stable until wr_valid&&wr_ready is seen on a rising edge.
  - On that edge: go to IDLE, wr_valid<=0, wr_addr<=wr_addr+1 (wraps from 2^ADDR_W-1 to 0), entry_word<=0, nibble_cnt<=0.
  - Enter and commit pulses arriving in WRITE are discarded.
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, entry_word 0, nibble_cnt 0, busy 0, err 0, state IDLE.
  - Debouncer stable levels, counters and synchronizer flops all reset to 0.
  - Reset asserted during WRITE drops wr_valid on that edge with no completed write. The next write goes to address 0.

## Timing
- Enter latency:
  - Raw button high from edge 0 onward → synchronizer output high after edge 2.
  - Stable level flips at edge DEBOUNCE_CYCLES+2.
  - Press pulse is high during the following cycle.
  - entry_word updates at edge DEBOUNCE_CYCLES+3.
- Commit accepted at edge N → wr_valid high from edge N.
  - With wr_ready tied high, the handshake completes at edge N+1.
- wr_valid never deasserts without a handshake, except on reset.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- One pulse per press regardless of hold length.

## Configuration
- LOADER_AUTOCOMMIT_EN defined:
  - The enter event that makes nibble_cnt reach 8 also starts the write. WRITE is entered on that same edge, with wr_data equal to the new 8-nibble word.
  - The commit button is ignored and err never pulses.
- Undefined: a write starts only on a commit pulse, as described under Operation.

## Test plan
- DEBOUNCE_CYCLES=4: raw enter high for 3 cycles, then low → no pulse, entry_word stays 0. Raw enter high for 10 cycles with key_nibble=A → entry_word=0x0000000A at edge 7, nibble_cnt=1.
- Enter nibbles 1,2,3,4,5,6,7,8, then commit with wr_ready=1 → one write with wr_addr=0, wr_data=0x12345678. Afterwards entry_word=0, nibble_cnt=0, wr_addr=1.
- Hold wr_ready=0 for 5 cycles after a commit → wr_valid, wr_addr and wr_data stay constant. Write completes on the first edge with wr_ready=1. Enter presses made during the stall are lost.
- Commit after only 3 nibbles → err pulses for exactly one cycle, no write, nibble_cnt stays 3. Nine enters of F then 0 → entry_word=0xFFFFFFF0.
- 256 writes with ADDR_W=8 → addresses 0..255, then the next write goes to 0. rst=0 during a stalled WRITE → wr_valid=0 and wr_addr=0 after that edge.
- LOADER_AUTOCOMMIT_EN defined: 8 enters of 9 → wr_valid rises on the 8th enter's edge with wr_data=0x99999999. Commit presses cause no err.

Source files
------------

// File: rtl/mips_hex_loader.sv
// Hex keypad word entry: two debounced buttons assemble a 32-bit word nibble by nibble and commit it over a valid/ready write port.
// Build option LOADER_AUTOCOMMIT_EN: the 8th nibble starts the write by itself and the commit button is ignored.
module mips_hex_loader #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int ADDR_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_nibble,
  input  logic              key_enter,
  input  logic              key_commit,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [31:0]       entry_word,
  output logic [3:0]        nibble_cnt,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {key_commit, key_enter};

  // Bit 0 is enter, bit 1 is commit; each gets its own synchronizer and debouncer.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             r_sync1;
      logic             r_sync2;
      logic             r_stable;
      logic             r_stable_d;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (!rst) begin
          r_sync1    <= 1'b0;
          r_sync2    <= 1'b0;
          r_stable   <= 1'b0;
          r_stable_d <= 1'b0;
          r_cnt      <= '0;
        end else begin
          r_sync1    <= w_raw[gi];
          r_sync2    <= r_sync1;
          r_stable_d <= r_stable;
          if (r_sync2 == r_stable) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_stable <= ~r_stable;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_stable & ~r_stable_d;
    end
  endgenerate

  logic              w_enter;
  logic              w_commit;
  logic [31:0]       w_shifted;
  logic [3:0]        w_cnt_inc;

  logic [0:0]        r_state;
  logic [31:0]       r_entry_word;
  logic [31:0]       r_wr_data;
  logic [3:0]        r_nibble_cnt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_valid;
  logic              r_err;

  assign w_enter   = w_press[0];
  assign w_commit  = w_press[1];
  assign w_shifted = {r_entry_word[27:0], key_nibble};
  assign w_cnt_inc = (r_nibble_cnt == 4'd8) ? 4'd8 : r_nibble_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_entry_word <= '0;
      r_wr_data    <= '0;
      r_nibble_cnt <= '0;
      r_wr_addr    <= '0;
      r_wr_valid   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (r_state == S_IDLE) begin
`ifdef LOADER_AUTOCOMMIT_EN
        if (w_enter) begin
          r_entry_word <= w_shifted;
          r_nibble_cnt <= w_cnt_inc;
          if (w_cnt_inc == 4'd8) begin
            r_wr_data  <= w_shifted;
            r_wr_valid <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
`else
        // Commit wins over a simultaneous enter; the enter is dropped.
        if (w_commit) begin
          if (r_nibble_cnt == 4'd8) begin
            r_wr_data  <= r_entry_word;
            r_wr_valid <= 1'b1;
            r_state    <= S_WRITE;
          end else begin
            r_err <= 1'b1;
          end
        end else if (w_enter) begin
          r_entry_word <= w_shifted;
          r_nibble_cnt <= w_cnt_inc;
        end
`endif
      end else begin
        // Button events during a write are ignored; only the handshake leaves this state.
        if (r_wr_valid && wr_ready) begin
          r_wr_valid   <= 1'b0;
          r_wr_addr    <= r_wr_addr + 1'b1;
          r_entry_word <= '0;
          r_nibble_cnt <= '0;
          r_state      <= S_IDLE;
        end
      end
    end
  end

  assign wr_valid   = r_wr_valid;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign entry_word = r_entry_word;
  assign nibble_cnt = r_nibble_cnt;
  assign busy       = (r_state == S_WRITE);
  assign err        = r_err;

endmodule

// File: tb/tb_mips_hex_loader.sv
// Self-checking bench for mips_hex_loader: reset, debounce timing, vector table, stall, random ops vs model, address wrap.
module tb_mips_hex_loader;
  localparam int DC = 4;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    key_nibble = '0;
  logic          key_enter = 1'b0;
  logic          key_commit = 1'b0;
  logic          wr_ready = 1'b0;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic [31:0]   entry_word;
  logic [3:0]    nibble_cnt;
  logic          busy;
  logic          err;

  mips_hex_loader #(.DEBOUNCE_CYCLES(DC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .key_nibble(key_nibble), .key_enter(key_enter),
    .key_commit(key_commit), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .entry_word(entry_word),
    .nibble_cnt(nibble_cnt), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;
  bit rand_ready = 1'b0;
  logic [AW-1:0] wq_addr[$];
  logic [31:0]   wq_data[$];

  // Completed handshakes and err-high cycles, sampled with pre-edge values.
  always @(posedge clk) begin
    if (err === 1'b1) err_pulses++;
    if (rst === 1'b1 && wr_valid === 1'b1 && wr_ready === 1'b1) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  typedef struct {
    bit            commit;
    logic [3:0]    nib;
    logic [31:0]   word;
    logic [3:0]    cnt;
    int            errs;
    int            writes;
    logic [AW-1:0] addr;
  } vec_t;
  vec_t vecs[$];

  // Reference model: plain arithmetic on the entry rules.
  logic [31:0]   m_word;
  int            m_cnt;
  logic [AW-1:0] m_addr;
  int            m_errs;
  logic [AW-1:0] ex_addr[$];
  logic [31:0]   ex_data[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic press(input bit commit, input logic [3:0] nib, input int hold, input int settle);
    key_nibble = nib;
    if (commit) key_commit = 1'b1;
    else key_enter = 1'b1;
    repeat (hold) tick();
    key_enter  = 1'b0;
    key_commit = 1'b0;
    repeat (settle) tick();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (wr_valid === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(name, {31'd0, wr_valid}, 32'd0);
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (wr_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check(name, {31'd0, wr_valid}, 32'd1);
  endtask

  task automatic model_press(input bit commit, input logic [3:0] nib);
    if (commit) begin
      if (m_cnt == 8) begin
        ex_addr.push_back(m_addr);
        ex_data.push_back(m_word);
        m_addr = m_addr + 1'b1;
        m_word = 32'd0;
        m_cnt  = 0;
      end else begin
        m_errs++;
      end
    end else begin
      m_word = (m_word << 4) | {28'd0, nib};
      if (m_cnt < 8) m_cnt++;
    end
  endtask

  task automatic enter_word(input logic [31:0] w);
    for (int k = 0; k < 8; k++) press(1'b0, w[31 - 4 * k -: 4], 5, 7);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    int base_err;
    int base_wr;
    int nwr;
    bit c;
    logic [3:0] nib;
    logic [31:0] w;

    repeat (3) tick();
    check("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_entry_word", entry_word, 32'd0);
    check("rst_nibble_cnt", {28'd0, nibble_cnt}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    tick();

    // Glitch one cycle shorter than the debounce window.
    press(1'b0, 4'h5, 3, 10);
    check("glitch_word", entry_word, 32'd0);
    check("glitch_cnt", {28'd0, nibble_cnt}, 32'd0);

    // Enter latency: update lands on the 7th edge after the raw rise.
    key_nibble = 4'hA;
    key_enter  = 1'b1;
    repeat (6) tick();
    check("lat_edge6_word", entry_word, 32'd0);
    tick();
    check("lat_edge7_word", entry_word, 32'h0000000A);
    check("lat_edge7_cnt", {28'd0, nibble_cnt}, 32'd1);
    repeat (3) tick();
    key_enter = 1'b0;
    repeat (10) tick();
    check("lat_one_pulse_cnt", {28'd0, nibble_cnt}, 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst2_word", entry_word, 32'd0);

`ifdef LOADER_AUTOCOMMIT_EN
    wr_ready = 1'b0;
    base_err = err_pulses;
    for (int k = 0; k < 7; k++) press(1'b0, 4'h9, 5, 7);
    key_nibble = 4'h9;
    key_enter  = 1'b1;
    repeat (6) tick();
    check("auto_edge6_valid", {31'd0, wr_valid}, 32'd0);
    tick();
    check("auto_edge7_valid", {31'd0, wr_valid}, 32'd1);
    check("auto_edge7_data", wr_data, 32'h99999999);
    key_enter = 1'b0;
    repeat (10) tick();
    press(1'b1, 4'h0, 5, 7);
    wr_ready = 1'b1;
    tick();
    check("auto_done_valid", {31'd0, wr_valid}, 32'd0);
    check("auto_done_addr", {24'd0, wr_addr}, 32'd1);
    press(1'b1, 4'h0, 5, 7);
    check("auto_commit_no_err", err_pulses - base_err, 32'd0);
    check("auto_commit_no_write", {31'd0, wr_valid}, 32'd0);
`else
    vecs.push_back('{1'b0, 4'h1, 32'h00000001, 4'd1, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h2, 32'h00000012, 4'd2, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h3, 32'h00000123, 4'd3, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h4, 32'h00001234, 4'd4, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h5, 32'h00012345, 4'd5, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h6, 32'h00123456, 4'd6, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h7, 32'h01234567, 4'd7, 0, 0, 8'd0});
    vecs.push_back('{1'b0, 4'h8, 32'h12345678, 4'd8, 0, 0, 8'd0});
    vecs.push_back('{1'b1, 4'h0, 32'h00000000, 4'd0, 0, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h0000000F, 4'd1, 0, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h000000FF, 4'd2, 0, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h00000FFF, 4'd3, 0, 1, 8'd1});
    vecs.push_back('{1'b1, 4'h0, 32'h00000FFF, 4'd3, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h0000FFFF, 4'd4, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h000FFFFF, 4'd5, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h00FFFFFF, 4'd6, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'h0FFFFFFF, 4'd7, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'hFFFFFFFF, 4'd8, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'hF, 32'hFFFFFFFF, 4'd8, 1, 1, 8'd1});
    vecs.push_back('{1'b0, 4'h0, 32'hFFFFFFF0, 4'd8, 1, 1, 8'd1});
    vecs.push_back('{1'b1, 4'h0, 32'h00000000, 4'd0, 1, 2, 8'd2});

    wr_ready = 1'b1;
    base_err = err_pulses;
    base_wr  = wq_addr.size();
    foreach (vecs[i]) begin
      press(vecs[i].commit, vecs[i].nib, 5, 7);
      check($sformatf("vec%0d_word", i), entry_word, vecs[i].word);
      check($sformatf("vec%0d_cnt", i), {28'd0, nibble_cnt}, {28'd0, vecs[i].cnt});
      check($sformatf("vec%0d_err", i), err_pulses - base_err, vecs[i].errs);
      check($sformatf("vec%0d_writes", i), wq_addr.size() - base_wr, vecs[i].writes);
      check($sformatf("vec%0d_addr", i), {24'd0, wr_addr}, {24'd0, vecs[i].addr});
    end
    if (wq_addr.size() >= base_wr + 2) begin
      check("vec_wr0_addr", {24'd0, wq_addr[base_wr]}, 32'd0);
      check("vec_wr0_data", wq_data[base_wr], 32'h12345678);
      check("vec_wr1_addr", {24'd0, wq_addr[base_wr + 1]}, 32'd1);
      check("vec_wr1_data", wq_data[base_wr + 1], 32'hFFFFFFF0);
    end else begin
      checks++;
      errors++;
      $display("FAIL vec_wr_queue: actual=%0d required=%0d", wq_addr.size() - base_wr, 2);
    end

    // Stalled write: port held steady, enters dropped.
    wr_ready = 1'b0;
    enter_word(32'h87654321);
    check("stall_word", entry_word, 32'h87654321);
    key_commit = 1'b1;
    repeat (5) tick();
    key_commit = 1'b0;
    wait_valid("stall_valid_rise");
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("stall%0d_valid", k), {31'd0, wr_valid}, 32'd1);
      check($sformatf("stall%0d_addr", k), {24'd0, wr_addr}, 32'd2);
      check($sformatf("stall%0d_data", k), wr_data, 32'h87654321);
    end
    press(1'b0, 4'h5, 5, 7);
    check("stall_lost_word", entry_word, 32'h87654321);
    check("stall_busy", {31'd0, busy}, 32'd1);
    nwr = wq_addr.size();
    wr_ready = 1'b1;
    tick();
    check("stall_done_valid", {31'd0, wr_valid}, 32'd0);
    check("stall_done_addr", {24'd0, wr_addr}, 32'd3);
    check("stall_done_word", entry_word, 32'd0);
    check("stall_done_cnt", {28'd0, nibble_cnt}, 32'd0);
    check("stall_done_writes", wq_addr.size() - nwr, 32'd1);

    // Random enter/commit sequence with random ready, against the model.
    m_word = 32'd0; m_cnt = 0; m_addr = 8'd3; m_errs = 0;
    ex_addr.delete(); ex_data.delete();
    base_err = err_pulses;
    base_wr  = wq_addr.size();
    rand_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      c   = ($urandom_range(0, 99) < 20);
      nib = 4'($urandom);
      press(c, nib, 5, 7);
      wait_idle($sformatf("rnd%0d_idle", i));
      model_press(c, nib);
      check($sformatf("rnd%0d_word", i), entry_word, m_word);
      check($sformatf("rnd%0d_cnt", i), {28'd0, nibble_cnt}, m_cnt);
      check($sformatf("rnd%0d_err", i), err_pulses - base_err, m_errs);
      check($sformatf("rnd%0d_writes", i), wq_addr.size() - base_wr, ex_addr.size());
    end
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    foreach (ex_addr[i]) begin
      if (base_wr + i < wq_addr.size()) begin
        check($sformatf("rnd_wr%0d_addr", i), {24'd0, wq_addr[base_wr + i]}, {24'd0, ex_addr[i]});
        check($sformatf("rnd_wr%0d_data", i), wq_data[base_wr + i], ex_data[i]);
      end
    end

    // Address wrap: 257 writes from address 0.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    for (int n = 0; n < 257; n++) begin
      w = $urandom;
      base_wr = wq_addr.size();
      enter_word(w);
      press(1'b1, 4'h0, 5, 7);
      if (wq_addr.size() == base_wr + 1) begin
        check($sformatf("wrap%0d_addr", n), {24'd0, wq_addr[base_wr]}, n % 256);
        check($sformatf("wrap%0d_data", n), wq_data[base_wr], w);
      end else begin
        checks++;
        errors++;
        $display("FAIL wrap%0d_writes: actual=%0d required=1", n, wq_addr.size() - base_wr);
      end
    end

    // Reset during a stalled write drops it.
    wr_ready = 1'b0;
    enter_word(32'hCCCCCCCC);
    key_commit = 1'b1;
    repeat (5) tick();
    key_commit = 1'b0;
    wait_valid("rstw_valid_rise");
    nwr = wq_addr.size();
    rst = 1'b0;
    tick();
    check("rstw_valid", {31'd0, wr_valid}, 32'd0);
    check("rstw_addr", {24'd0, wr_addr}, 32'd0);
    check("rstw_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    wr_ready = 1'b1;
    repeat (12) tick();
    check("rstw_no_write", wq_addr.size() - nwr, 32'd0);
    enter_word(32'h0BADF00D);
    press(1'b1, 4'h0, 5, 7);
    if (wq_addr.size() == nwr + 1) begin
      check("rstw_next_addr", {24'd0, wq_addr[nwr]}, 32'd0);
      check("rstw_next_data", wq_data[nwr], 32'h0BADF00D);
    end else begin
      checks++;
      errors++;
      $display("FAIL rstw_next_writes: actual=%0d required=1", wq_addr.size() - nwr);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
